game_round_ctrl: RTL and testbench



---
 rtl/game_round_ctrl.sv | 147 ++++++++++++++
 tb/tb_game_round_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/game_round_ctrl.sv
// Purpose : round sequencer for the LED score game (IDLE attract -> COUNTDOWN -> PLAY hit window
//           -> RESULT score blink); drives score/led_control into the display mux.
// Latency : start rise sampled at edge k gives COUNTDOWN outputs right after edge k; all outputs registered.
// Backpressure: none; buttons are level inputs and the display mux always accepts.
// Ports   : clk, reset (sync, active-high), start/hit (debounced button levels),
//           score[6:0] (current/last round hits), led_control[1:0] (00 off, 01 score, 10 attract, 11 all on),
//           busy (state != IDLE), round_done (one-cycle pulse on RESULT entry).
module game_round_ctrl #(
    parameter int TICK_DIV     = 50_000_000,
    parameter int COUNT_TICKS  = 3,
    parameter int PLAY_TICKS   = 10,
    parameter int RESULT_TICKS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       hit,
    output logic [6:0] score,
    output logic [1:0] led_control,
    output logic       busy,
    output logic       round_done
);

    localparam int PW   = $clog2(TICK_DIV);
    localparam int TMAX = (COUNT_TICKS > PLAY_TICKS)
                          ? ((COUNT_TICKS > RESULT_TICKS) ? COUNT_TICKS : RESULT_TICKS)
                          : ((PLAY_TICKS > RESULT_TICKS) ? PLAY_TICKS : RESULT_TICKS);
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [1:0] LED_OFF     = 2'b00;
    localparam logic [1:0] LED_SCORE   = 2'b01;
    localparam logic [1:0] LED_ATTRACT = 2'b10;
    localparam logic [1:0] LED_ALL_ON  = 2'b11;

    localparam logic [PW-1:0] PRE_LAST     = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] COUNT_LAST   = TW'(COUNT_TICKS - 1);
    localparam logic [TW-1:0] PLAY_LAST    = TW'(PLAY_TICKS - 1);
    localparam logic [TW-1:0] RESULT_LAST  = TW'(RESULT_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COUNTDOWN = 2'd1,
        PLAY      = 2'd2,
        RESULT    = 2'd3
    } state_t;

    state_t        state;
    logic [PW-1:0] prescaler;
    logic [TW-1:0] tick_cnt;
    logic          blink;
    logic          start_q;
    logic          hit_q;

    logic tick;
    logic start_rise;
    logic hit_rise;

    assign tick       = (prescaler == PRE_LAST);
    assign start_rise = start & ~start_q;
    assign hit_rise   = hit & ~hit_q;

    always_ff @(posedge clk) begin
        // Button history is tracked even in reset so a button held through
        // reset release never looks like a fresh press.
        start_q <= start;
        hit_q   <= hit;

        if (reset) begin
            state       <= IDLE;
            score       <= 7'd0;
            prescaler   <= '0;
            tick_cnt    <= '0;
            blink       <= 1'b0;
            round_done  <= 1'b0;
            led_control <= LED_ATTRACT;
            busy        <= 1'b0;
        end else begin
            round_done <= 1'b0;

            // Free-running tick base; every state transition below overrides
            // both counters back to zero so each state lasts an exact number of ticks.
            if (tick) begin
                prescaler <= '0;
                tick_cnt  <= tick_cnt + TW'(1);
            end else begin
                prescaler <= prescaler + PW'(1);
            end

            case (state)
                IDLE: begin
                    prescaler <= '0;
                    tick_cnt  <= '0;
                    if (start_rise) begin
                        state       <= COUNTDOWN;
                        score       <= 7'd0;
                        led_control <= LED_ALL_ON;
                        busy        <= 1'b1;
                    end
                end

                COUNTDOWN: begin
                    if (tick && tick_cnt == COUNT_LAST) begin
                        state       <= PLAY;
                        tick_cnt    <= '0;
                        led_control <= LED_SCORE;
                    end
                end

                PLAY: begin
                    // Counted on every PLAY cycle including the last one; the edge
                    // in the cycle that enters PLAY was seen while still in COUNTDOWN.
                    if (hit_rise && score != 7'd127) begin
                        score <= score + 7'd1;
                    end
                    if (tick && tick_cnt == PLAY_LAST) begin
                        state       <= RESULT;
                        tick_cnt    <= '0;
                        blink       <= 1'b1;
                        led_control <= LED_SCORE;
                        round_done  <= 1'b1;
                    end
                end

                RESULT: begin
                    if (tick) begin
                        blink       <= ~blink;
                        led_control <= blink ? LED_OFF : LED_SCORE;
                    end
                    if (tick && tick_cnt == RESULT_LAST) begin
                        state       <= IDLE;
                        tick_cnt    <= '0;
                        blink       <= 1'b0;
                        led_control <= LED_ATTRACT;
                        busy        <= 1'b0;
                    end
                end

                default: begin
                    state       <= IDLE;
                    led_control <= LED_ATTRACT;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_round_ctrl.sv
module tb_game_round_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       hit;
    logic [6:0] score;
    logic [1:0] led_control;
    logic       busy;
    logic       round_done;

    // Second instance with a long PLAY window for the saturation run.
    logic       start2;
    logic       hit2;
    logic [6:0] score2;
    logic [1:0] led_control2;
    logic       busy2;
    logic       round_done2;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    game_round_ctrl #(
        .TICK_DIV(4), .COUNT_TICKS(3), .PLAY_TICKS(10), .RESULT_TICKS(4)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .hit(hit),
        .score(score), .led_control(led_control), .busy(busy), .round_done(round_done)
    );

    game_round_ctrl #(
        .TICK_DIV(32), .COUNT_TICKS(1), .PLAY_TICKS(10), .RESULT_TICKS(1)
    ) dut_sat (
        .clk(clk), .reset(reset), .start(start2), .hit(hit2),
        .score(score2), .led_control(led_control2), .busy(busy2), .round_done(round_done2)
    );

    task automatic chk(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Check led_control for n consecutive cycles, driving hit/start from masks.
    task automatic expect_run(input string tag, input logic [1:0] led, input int n,
                              input logic [63:0] hm, input logic [63:0] sm);
        for (int i = 0; i < n; i++) begin
            chk(tag, int'(led_control), int'(led));
            hit   = hm[i];
            start = sm[i];
            cyc();
        end
        hit   = 1'b0;
        start = 1'b0;
    endtask

    task automatic start_round(input string tag);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk({tag, "_cd_led"}, int'(led_control), 3);
        chk({tag, "_cd_busy"}, int'(busy), 1);
        chk({tag, "_cd_score_clr"}, int'(score), 0);
    endtask

    task automatic full_round(input string tag, input int exp_score,
                              input logic [63:0] cm, input logic [63:0] pm,
                              input logic [63:0] rm, input logic [63:0] scm,
                              input logic [63:0] spm);
        expect_run({tag, "_countdown"}, 2'b11, 12, cm, scm);
        expect_run({tag, "_play"}, 2'b01, 40, pm, spm);
        chk({tag, "_rd_pulse"}, int'(round_done), 1);
        chk({tag, "_res_score"}, int'(score), exp_score);
        expect_run({tag, "_res_on1"}, 2'b01, 4, rm, 64'h0);
        chk({tag, "_rd_low"}, int'(round_done), 0);
        expect_run({tag, "_res_off1"}, 2'b00, 4, 64'h0, 64'h0);
        expect_run({tag, "_res_on2"}, 2'b01, 4, 64'h0, 64'h0);
        expect_run({tag, "_res_off2"}, 2'b00, 4, 64'h0, 64'h0);
        chk({tag, "_idle_led"}, int'(led_control), 2);
        chk({tag, "_idle_busy"}, int'(busy), 0);
        chk({tag, "_idle_score"}, int'(score), exp_score);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        reset  = 1'b1;
        start  = 1'b0;
        hit    = 1'b0;
        start2 = 1'b0;
        hit2   = 1'b0;
        cyc();
        cyc();
        chk("rst_score", int'(score), 0);
        chk("rst_led", int'(led_control), 2);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rd", int'(round_done), 0);
        reset = 1'b0;

        // Idle attract, hits ignored.
        for (int i = 0; i < 20; i++) begin
            hit = (i == 5);
            cyc();
            chk("idle_led", int'(led_control), 2);
            chk("idle_score", int'(score), 0);
            chk("idle_busy", int'(busy), 0);
            chk("idle_rd", int'(round_done), 0);
        end
        hit = 1'b0;

        // Plain round, no hits: exact phase lengths.
        start_round("r0");
        full_round("r0", 0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0);

        // Hits in COUNTDOWN (2, ignored), PLAY (5, one on the final cycle), RESULT (1, ignored).
        start_round("r1");
        full_round("r1", 5, 64'h14, 64'h80_0000_00AA, 64'h2, 64'h0, 64'h0);
        cyc();
        chk("r1_idle_hold", int'(score), 5);

        // New start clears 5 -> 0; hit rises on the COUNTDOWN->PLAY edge and is held for all of PLAY.
        start_round("r2");
        full_round("r2", 0, 64'h800, 64'hFF_FFFF_FFFF, 64'h0, 64'h0, 64'h0);

        // Toggle every other cycle (20 rises); start pulsed in COUNTDOWN and PLAY must not restart.
        start_round("r3");
        full_round("r3", 20, 64'h0, 64'hAA_AAAA_AAAA, 64'h0, 64'h20, 64'h400);

        // Reset mid-PLAY with score 3, start held through reset release.
        start_round("r4");
        expect_run("r4_countdown", 2'b11, 12, 64'h0, 64'h0);
        expect_run("r4_play", 2'b01, 8, 64'h2A, 64'h0);
        chk("r4_score_mid", int'(score), 3);
        reset = 1'b1;
        start = 1'b1;
        cyc();
        chk("r4_rst_score", int'(score), 0);
        chk("r4_rst_led", int'(led_control), 2);
        chk("r4_rst_busy", int'(busy), 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("r4_held_led", int'(led_control), 2);
            chk("r4_held_busy", int'(busy), 0);
        end
        start = 1'b0;
        cyc();
        chk("r4_fall_led", int'(led_control), 2);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("r4_restart_led", int'(led_control), 3);
        chk("r4_restart_busy", int'(busy), 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();

        // Saturation: 150 hit rises inside a 320-cycle PLAY window.
        start2 = 1'b1;
        cyc();
        start2 = 1'b0;
        chk("sat_cd_led", int'(led_control2), 3);
        cnt = 0;
        while (led_control2 != 2'b01 && cnt < 200) begin
            cyc();
            cnt++;
        end
        chk("sat_cd_len", cnt, 32);
        for (int i = 0; i < 300; i++) begin
            hit2 = (i % 2 == 1);
            cyc();
        end
        hit2 = 1'b0;
        chk("sat_led", int'(led_control2), 1);
        chk("sat_score", int'(score2), 127);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
